alu_host_initiator: RTL and testbench

ALU_HOST_INITIATOR -- requirements
Module: alu_host_initiator

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/timeout_ctr.sv | 34 +++
 rtl/alu_host_initiator.sv | 160 ++++++++++++++++
 tb/tb_alu_host_initiator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU host initiator.
//   - opcode constants for the four supported operations
//   - command header constants and frame byte counts
//   - FSM state enum
//   - helpers: opcode support test and command byte selection
package alu_pkg;

  localparam logic [7:0] OP_ADD = 8'hAD;
  localparam logic [7:0] OP_SUB = 8'h5B;
  localparam logic [7:0] OP_MUL = 8'h88;
  localparam logic [7:0] OP_AND = 8'hA7;

  // Header after the opcode: reserved, length, reserved.
  localparam logic [7:0] HDR_RSVD = 8'h00;
  localparam logic [7:0] HDR_LEN  = 8'h0C;

  localparam int CMD_BYTES = 12;
  localparam int RSP_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic op_supported(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_AND);
  endfunction

  // Byte idx of the outgoing frame: opcode, header, a (LSB first), b (LSB first).
  function automatic logic [7:0] cmd_byte(input logic [3:0]  idx,
                                          input logic [7:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [7:0] r;
    case (idx)
      4'd0:    r = op;
      4'd1:    r = HDR_RSVD;
      4'd2:    r = HDR_LEN;
      4'd3:    r = HDR_RSVD;
      4'd4:    r = a[7:0];
      4'd5:    r = a[15:8];
      4'd6:    r = a[23:16];
      4'd7:    r = a[31:24];
      4'd8:    r = b[7:0];
      4'd9:    r = b[15:8];
      4'd10:   r = b[23:16];
      4'd11:   r = b[31:24];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timeout_ctr.sv
// Saturating cycle counter used to bound the wait for a response.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - synchronous clear to zero (takes priority over enable)
//   enable  - count one per cycle while asserted
//   expired - high while the count equals LIMIT
module timeout_ctr #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

  logic [CW-1:0] count;

  // Stops at LIMIT so expired stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT_V);

endmodule

// File: rtl/alu_host_initiator.sv
// Host-side initiator for a UART-attached ALU. Accepts a command, serialises
// it as a 12-byte frame on m_axis, collects a 4-byte little-endian result on
// s_axis, and presents it (or a timeout) on the rsp interface.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cmd_*              - command request (valid/ready), opcode and operands
//   m_axis_*           - byte stream toward the UART transmitter
//   s_axis_*           - byte stream from the UART receiver
//   rsp_valid/ready    - result handshake; rsp_data, rsp_timeout qualify it
//   cmd_err            - one-cycle pulse after an unsupported opcode is taken
//   dbg_state          - current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds data stable while valid is high and ready low,
// and valid never depends on ready.
module alu_host_initiator
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        cmd_err,
  output state_t      dbg_state
);

  state_t      state;
  state_t      state_d;
  logic [3:0]  byte_idx;
  logic [7:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic cmd_fire;
  logic tx_fire;
  logic rx_fire;
  logic last_tx;
  logic last_rx;
  logic expired;

  assign cmd_ready     = (state == ST_IDLE);
  assign m_axis_tvalid = (state == ST_SEND);
  // Index only moves on a handshake, so tdata is stable under backpressure.
  assign m_axis_tdata  = (state == ST_SEND) ? cmd_byte(byte_idx, op_q, a_q, b_q) : 8'h00;
  // Receiver is drained outside WAIT_RSP too; such bytes are simply dropped.
  assign s_axis_tready = (state != ST_DONE);
  assign rsp_valid     = (state == ST_DONE);
  assign dbg_state     = state;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign tx_fire  = m_axis_tvalid && m_axis_tready;
  assign rx_fire  = s_axis_tvalid && s_axis_tready && (state == ST_WAIT_RSP);
  assign last_tx  = (byte_idx == 4'(CMD_BYTES - 1));
  assign last_rx  = (byte_idx == 4'(RSP_BYTES - 1));

  timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_WAIT_RSP),
    .enable  (state == ST_WAIT_RSP),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && op_supported(cmd_opcode)) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_fire && last_tx) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // A final byte on the expiry cycle still completes the response.
        if ((rx_fire && last_rx) || expired) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx    <= 4'd0;
      op_q        <= 8'h00;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      rsp_data    <= 32'h0;
      rsp_timeout <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (op_supported(cmd_opcode)) begin
              op_q        <= cmd_opcode;
              a_q         <= cmd_a;
              b_q         <= cmd_b;
              byte_idx    <= 4'd0;
              rsp_data    <= 32'h0;
              rsp_timeout <= 1'b0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (tx_fire) byte_idx <= last_tx ? 4'd0 : byte_idx + 4'd1;
        end
        ST_WAIT_RSP: begin
          if (rx_fire && last_rx) begin
            rsp_data[{byte_idx[1:0], 3'b000} +: 8] <= s_axis_tdata;
            rsp_timeout <= 1'b0;
            byte_idx    <= 4'd0;
          end else if (expired) begin
            rsp_data    <= 32'h0;
            rsp_timeout <= 1'b1;
            byte_idx    <= 4'd0;
          end else if (rx_fire) begin
            rsp_data[{byte_idx[1:0], 3'b000} +: 8] <= s_axis_tdata;
            byte_idx <= byte_idx + 4'd1;
          end
        end
        ST_DONE: begin
          byte_idx <= 4'd0;
        end
        default: byte_idx <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_initiator.sv
// Self-checking bench for alu_host_initiator. Inputs are driven on the
// falling edge; outputs (all functions of registered state) are sampled 1ns
// later, and a handshake seen there completes on the following rising edge.
module tb_alu_host_initiator;
  import alu_pkg::*;

  localparam int TO = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [31:0] cmd_a = 32'h0;
  logic [31:0] cmd_b = 32'h0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        cmd_err;
  state_t      dbg_state;

  alu_host_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .cmd_err       (cmd_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] r;
    case (op)
      8'hAD:   r = a + b;
      8'h5B:   r = a - b;
      8'h88:   r = a * b;
      8'hA7:   r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.delete();
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((b >> (8 * i)) & 32'hFF));
  endtask

  // ---------------- driver tasks ----------------
  // tr_mode: 0 tready high, 1 toggling, 2 random (plus noise on s_axis during SEND).
  // n_rsp bytes are returned; last_at >= 0 pins the 4th byte to that WAIT_RSP cycle.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int tr_mode, input int n_rsp, input int last_at, input int hold);
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_to;
    logic [7:0]  prev_tdata;
    logic        prev_stall;
    logic        send_now;
    int cyc, wait_idx, rx, last_rx_idx, exp_done;
    bit done;

    word     = model_result(op, a, b);
    exp_to   = (n_rsp < 4);
    exp_data = exp_to ? 32'h0 : word;
    model_frame(op, a, b);
    got_q.delete();

    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;

    cyc = 0; wait_idx = -1; rx = 0; last_rx_idx = 0; done = 0;
    prev_stall = 0; prev_tdata = 8'h00;
    while (!done && cyc < 2000) begin
      if (cyc > 0) @(negedge clk);
      case (tr_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ((cyc % 2) == 1);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      send_now = 1'b0;
      if (wait_idx >= 0 && rx < n_rsp) begin
        if (last_at >= 0) send_now = (rx < 3) ? 1'b1 : (wait_idx == last_at);
        else send_now = ($urandom_range(0, 1) == 1) || (wait_idx >= 20);
      end
      if (send_now) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'((word >> (8 * rx)) & 32'hFF);
      end else if (wait_idx < 0 && tr_mode == 2) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = 8'($urandom_range(0, 255));
      end else begin
        s_axis_tvalid = 1'b0;
      end
      rsp_ready = 1'b0;
      #1;
      if (cyc == 0) check("first_tvalid_latency", m_axis_tvalid, 1);
      if (prev_stall) check("tdata_stable_stall", m_axis_tdata, prev_tdata);
      if (wait_idx >= 0) check("no_tvalid_after_send", m_axis_tvalid, 0);
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      if (send_now && s_axis_tready) begin
        rx++;
        last_rx_idx = wait_idx;
      end
      if (rsp_valid) begin
        done = 1;
        exp_done = (n_rsp >= 4) ? last_rx_idx + 1 : TO + 1;
        check("rsp_valid_cycle", wait_idx, exp_done);
      end
      if (wait_idx >= 0) wait_idx++;
      else if (got_q.size() == 12) wait_idx = 0;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    if (!done) check("rsp_valid_budget", 0, 1);

    check("tx_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size()) check("tx_byte", got_q[i], exp_q[i]);

    if (done) begin
      check("rsp_data", rsp_data, exp_data);
      check("rsp_timeout", rsp_timeout, exp_to);
      check("s_tready_done", s_axis_tready, 0);
      check("cmd_ready_done", cmd_ready, 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_data", rsp_data, exp_data);
        check("hold_rsp_timeout", rsp_timeout, exp_to);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1 check("rsp_valid_at_ready", rsp_valid, 1);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("idle_after_rsp", cmd_ready, 1);
      check("rsp_valid_cleared", rsp_valid, 0);
    end
  endtask

  task automatic run_bad_opcode(input logic [7:0] op);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; m_axis_tready = 1'b1;
    #1 check("bad_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("cmd_err_pulse", cmd_err, 1);
    check("bad_cmd_ready_after", cmd_ready, 1);
    check("bad_no_tvalid", m_axis_tvalid, 0);
    @(negedge clk);
    #1 check("cmd_err_one_cycle", cmd_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bad_no_tvalid_later", m_axis_tvalid, 0);
      check("bad_idle_later", cmd_ready, 1);
    end
  endtask

  task automatic run_abort(input logic [31:0] a, input logic [31:0] b);
    int guard;
    model_frame(8'hAD, a, b);
    got_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 8'hAD; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0; m_axis_tready = 1'b1;
    guard = 0;
    while (got_q.size() < 5 && guard < 100) begin
      #1;
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
      guard++;
      if (got_q.size() < 5) @(negedge clk);
    end
    check("abort_reach_5th", got_q.size(), 5);
    @(negedge clk);
    m_axis_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("abort_idle", cmd_ready, 1);
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_tdata", m_axis_tdata, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    end
    check("abort_tx_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check("abort_tx_byte", got_q[i], exp_q[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] ops[4];
    ops[0] = 8'hAD; ops[1] = 8'h5B; ops[2] = 8'h88; ops[3] = 8'hA7;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    run_cmd(8'hAD, 32'h3, 32'h4, 0, 4, -1, 0);
    check("add_known_result", rsp_data, 32'h7);
    run_cmd(8'h88, 32'h12345678, 32'h2, 1, 4, -1, 0);
    run_bad_opcode(8'h42);
    run_cmd(8'hA7, $urandom, $urandom, 0, 2, -1, 2);
    run_cmd(8'h5B, $urandom, $urandom, 0, 4, TO, 1);
    run_abort($urandom, $urandom);
    run_cmd(8'h5B, 32'd10, 32'd3, 0, 4, -1, 10);

    for (int t = 0; t < 6; t++)
      run_cmd(ops[$urandom_range(0, 3)], $urandom, $urandom, 2, 4, -1,
              $urandom_range(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
